// File: rtl/dual_port_ram_be.sv
// Dual-port byte-enable RAM with post-reset clear, selectable read-during-write mode and
// write-write collision flag. Define OUT_REG_EN for an extra output register (read latency 2).
module dual_port_ram_be #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 16,
    localparam int unsigned     ADDR     = $clog2(DEPTH),
    parameter int unsigned      MODE     = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 busy,
    input  logic                 en1,
    input  logic                 rd_en1,
    input  logic [WIDTH/8-1:0]   be1,
    input  logic [ADDR-1:0]      addr1,
    input  logic [WIDTH-1:0]     data_in1,
    output logic [WIDTH-1:0]     data_out1,
    output logic                 valid1,
    input  logic                 en2,
    input  logic                 rd_en2,
    input  logic [WIDTH/8-1:0]   be2,
    input  logic [ADDR-1:0]      addr2,
    input  logic [WIDTH-1:0]     data_in2,
    output logic [WIDTH-1:0]     data_out2,
    output logic                 valid2,
    output logic                 collision
);

    localparam int unsigned   BYTES    = WIDTH / 8;
    localparam logic [ADDR:0] DepthW   = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR-1:0] LastAddr = ADDR'(DEPTH - 1);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]      state_q, state_d;
    logic [ADDR-1:0] cnt_q, cnt_d;

    logic             ready;
    logic             in_range1, in_range2;
    logic             wr1, wr2, rd1, rd2;
    logic [WIDTH-1:0] rdata1, rdata2;

    logic [WIDTH-1:0] dout1_q, dout2_q;
    logic             vld1_q, vld2_q;
    logic             coll_q;

    assign ready     = (state_q == StReady);
    assign busy      = (state_q == StClear);
    assign in_range1 = ({1'b0, addr1} < DepthW);
    assign in_range2 = ({1'b0, addr2} < DepthW);

    // A write with no byte enabled is not a write at all (no collision either).
    assign wr1 = ready && en1 && !rd_en1 && in_range1 && (|be1);
    assign wr2 = ready && en2 && !rd_en2 && in_range2 && (|be2);
    assign rd1 = ready && en1 && rd_en1;
    assign rd2 = ready && en2 && rd_en2;

    // Clear sequencer: one word per cycle, leaves CLEAR on the edge writing the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            if (cnt_q == LastAddr) begin
                state_d = StReady;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While rst is held this rewrites INIT_VAL to word 0, which the clear redoes anyway.
    // Port 1 is assigned last so it wins bytes enabled on both ports.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= INIT_VAL;
        end else begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr2 && be2[b]) mem[addr2][8*b +: 8] <= data_in2[8*b +: 8];
                if (wr1 && be1[b]) mem[addr1][8*b +: 8] <= data_in1[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata1 = in_range1 ? mem[addr1] : '0;
        rdata2 = in_range2 ? mem[addr2] : '0;
        if (MODE == 1) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr2 && (addr2 == addr1) && be2[b]) rdata1[8*b +: 8] = data_in2[8*b +: 8];
                if (wr1 && (addr1 == addr2) && be1[b]) rdata2[8*b +: 8] = data_in1[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1_q <= '0;
            dout2_q <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            if (rd1) dout1_q <= rdata1;
            if (rd2) dout2_q <= rdata2;
            vld1_q <= rd1;
            vld2_q <= rd2;
            coll_q <= wr1 && wr2 && (addr1 == addr2);
        end
    end

    assign collision = coll_q;

`ifdef OUT_REG_EN
    logic [WIDTH-1:0] pipe1_q, pipe2_q;
    logic             pvld1_q, pvld2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe1_q <= '0;
            pipe2_q <= '0;
            pvld1_q <= 1'b0;
            pvld2_q <= 1'b0;
        end else begin
            if (vld1_q) pipe1_q <= dout1_q;
            if (vld2_q) pipe2_q <= dout2_q;
            pvld1_q <= vld1_q;
            pvld2_q <= vld2_q;
        end
    end

    assign data_out1 = pipe1_q;
    assign data_out2 = pipe2_q;
    assign valid1    = pvld1_q;
    assign valid2    = pvld2_q;
`else
    assign data_out1 = dout1_q;
    assign data_out2 = dout2_q;
    assign valid1    = vld1_q;
    assign valid2    = vld2_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: DUT a is DEPTH=16/MODE=0, DUT b is DEPTH=12/MODE=1, inputs shared.
module tb_dual_port_ram_be;

`ifdef OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en1, rd_en1, en2, rd_en2;
    logic [1:0]  be1, be2;
    logic [3:0]  addr1, addr2;
    logic [15:0] data_in1, data_in2;

    logic        busy_a, v1_a, v2_a, col_a;
    logic [15:0] do1_a, do2_a;
    logic        busy_b, v1_b, v2_b, col_b;
    logic [15:0] do1_b, do2_b;

    int total = 0;
    int bad   = 0;

    dual_port_ram_be #(.WIDTH(16), .DEPTH(16), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .busy(busy_a),
        .en1(en1), .rd_en1(rd_en1), .be1(be1), .addr1(addr1), .data_in1(data_in1),
        .data_out1(do1_a), .valid1(v1_a),
        .en2(en2), .rd_en2(rd_en2), .be2(be2), .addr2(addr2), .data_in2(data_in2),
        .data_out2(do2_a), .valid2(v2_a),
        .collision(col_a)
    );

    dual_port_ram_be #(.WIDTH(16), .DEPTH(12), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .busy(busy_b),
        .en1(en1), .rd_en1(rd_en1), .be1(be1), .addr1(addr1), .data_in1(data_in1),
        .data_out1(do1_b), .valid1(v1_b),
        .en2(en2), .rd_en2(rd_en2), .be2(be2), .addr2(addr2), .data_in2(data_in2),
        .data_out2(do2_b), .valid2(v2_b),
        .collision(col_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en1 = 0; rd_en1 = 0; be1 = 0; addr1 = 0; data_in1 = 0;
        en2 = 0; rd_en2 = 0; be2 = 0; addr2 = 0; data_in2 = 0;
    endtask

    task automatic set_wr1(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        en1 = 1; rd_en1 = 0; addr1 = a; data_in1 = d; be1 = b;
    endtask

    task automatic set_wr2(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        en2 = 1; rd_en2 = 0; addr2 = a; data_in2 = d; be2 = b;
    endtask

    task automatic set_rd1(input logic [3:0] a);
        en1 = 1; rd_en1 = 1; addr1 = a; be1 = 0;
    endtask

    task automatic set_rd2(input logic [3:0] a);
        en2 = 1; rd_en2 = 1; addr2 = a; be2 = 0;
    endtask

    // Brings read data to the output after the request edge has been taken.
    task automatic settle();
        idle();
        repeat (LAT - 1) tick();
    endtask

    // Counts cycles after reset release until busy falls on each DUT.
    task automatic count_busy(output int na, output int nb, input logic drive_busy_req);
        na = 0;
        nb = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1 && drive_busy_req) begin
                total++;
                if (v2_a !== 1'b0) begin
                    bad++; $display("FAIL busy_read_valid_a: got %0b expected 0", v2_a);
                end
                total++;
                if (v2_b !== 1'b0) begin
                    bad++; $display("FAIL busy_read_valid_b: got %0b expected 0", v2_b);
                end
                idle();
            end
            if (!busy_a && na == 0) na = n;
            if (!busy_b && nb == 0) nb = n;
            if (na != 0 && nb != 0) break;
        end
    endtask

    task automatic test_reset();
        int na, nb;
        idle();
        rst = 1;
        repeat (2) tick();
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL rst_busy_a: got %0b expected 1", busy_a); end
        total++;
        if (busy_b !== 1'b1) begin bad++; $display("FAIL rst_busy_b: got %0b expected 1", busy_b); end
        total++;
        if (do1_a !== 16'h0 || do2_a !== 16'h0) begin
            bad++; $display("FAIL rst_dout_a: got %h/%h expected 0000/0000", do1_a, do2_a);
        end
        total++;
        if (v1_a !== 1'b0 || v2_a !== 1'b0 || col_a !== 1'b0) begin
            bad++; $display("FAIL rst_flags_a: got v1=%0b v2=%0b col=%0b expected 0", v1_a, v2_a, col_a);
        end
        rst = 0;
        count_busy(na, nb, 1'b0);
        total++;
        if (na != 16) begin bad++; $display("FAIL busy_len_a: got %0d expected 16", na); end
        total++;
        if (nb != 12) begin bad++; $display("FAIL busy_len_b: got %0d expected 12", nb); end
    endtask

    task automatic test_read_init();
        set_rd1(4'd5);
        set_rd2(4'd5);
        tick();
        settle();
        total++;
        if (v1_a !== 1'b1 || v2_a !== 1'b1) begin
            bad++; $display("FAIL init_valid_a: got %0b/%0b expected 1/1", v1_a, v2_a);
        end
        total++;
        if (do1_a !== 16'h0000 || do2_a !== 16'h0000) begin
            bad++; $display("FAIL init_data_a: got %h/%h expected 0000/0000", do1_a, do2_a);
        end
        total++;
        if (v1_b !== 1'b1 || do2_b !== 16'h0000) begin
            bad++; $display("FAIL init_b: got v=%0b d=%h expected 1/0000", v1_b, do2_b);
        end
        tick();
        total++;
        if (v1_a !== 1'b0) begin bad++; $display("FAIL init_valid_pulse: got %0b expected 0", v1_a); end
    endtask

    task automatic test_byte_enable();
        set_wr1(4'd3, 16'hA5C3, 2'b11);
        tick();
        idle();
        set_wr2(4'd3, 16'h1200, 2'b10);
        tick();
        total++;
        if (v1_a !== 1'b0) begin bad++; $display("FAIL be_write_valid: got %0b expected 0", v1_a); end
        idle();
        set_wr1(4'd3, 16'hFFFF, 2'b00);
        tick();
        idle();
        set_rd1(4'd3);
        tick();
        idle();
`ifdef OUT_REG_EN
        total++;
        if (v1_a !== 1'b0) begin bad++; $display("FAIL outreg_early_valid: got %0b expected 0", v1_a); end
        tick();
`endif
        total++;
        if (do1_a !== 16'h12C3 || v1_a !== 1'b1) begin
            bad++; $display("FAIL be_merge_a: got %h v=%0b expected 12c3 v=1", do1_a, v1_a);
        end
        total++;
        if (do1_b !== 16'h12C3) begin bad++; $display("FAIL be_merge_b: got %h expected 12c3", do1_b); end
        tick();
        total++;
        if (do1_a !== 16'h12C3 || v1_a !== 1'b0) begin
            bad++; $display("FAIL be_hold: got %h v=%0b expected 12c3 v=0", do1_a, v1_a);
        end
    endtask

    task automatic test_rdw_mode();
        set_wr1(4'd7, 16'h00FF, 2'b11);
        tick();
        set_wr1(4'd7, 16'hBEEF, 2'b01);
        set_rd2(4'd7);
        tick();
        total++;
        if (col_a !== 1'b0 || col_b !== 1'b0) begin
            bad++; $display("FAIL rdw_no_collision: got %0b/%0b expected 0/0", col_a, col_b);
        end
        settle();
        total++;
        if (do2_a !== 16'h00FF) begin bad++; $display("FAIL rdw_read_first: got %h expected 00ff", do2_a); end
        total++;
        if (do2_b !== 16'h00EF) begin bad++; $display("FAIL rdw_write_first: got %h expected 00ef", do2_b); end
        set_rd1(4'd7);
        tick();
        settle();
        total++;
        if (do1_a !== 16'h00EF) begin bad++; $display("FAIL rdw_after: got %h expected 00ef", do1_a); end
    endtask

    task automatic test_collision();
        set_wr1(4'd9, 16'h1111, 2'b11);
        set_wr2(4'd9, 16'h2222, 2'b11);
        tick();
        total++;
        if (col_a !== 1'b1 || col_b !== 1'b1) begin
            bad++; $display("FAIL coll_flag: got %0b/%0b expected 1/1", col_a, col_b);
        end
        set_wr1(4'd10, 16'h00AA, 2'b01);
        set_wr2(4'd10, 16'hBB00, 2'b10);
        tick();
        total++;
        if (col_a !== 1'b1) begin bad++; $display("FAIL coll_disjoint: got %0b expected 1", col_a); end
        set_wr1(4'd11, 16'h3333, 2'b11);
        set_wr2(4'd4, 16'h4444, 2'b11);
        tick();
        total++;
        if (col_a !== 1'b0) begin bad++; $display("FAIL coll_diff_addr: got %0b expected 0", col_a); end
        idle();
        set_rd1(4'd9);
        set_rd2(4'd10);
        tick();
        settle();
        total++;
        if (do1_a !== 16'h1111 || do1_b !== 16'h1111) begin
            bad++; $display("FAIL coll_port1_wins: got %h/%h expected 1111/1111", do1_a, do1_b);
        end
        total++;
        if (do2_a !== 16'hBBAA || do2_b !== 16'hBBAA) begin
            bad++; $display("FAIL coll_merge: got %h/%h expected bbaa/bbaa", do2_a, do2_b);
        end
    endtask

    task automatic test_out_of_range();
        set_wr1(4'd13, 16'h5A5A, 2'b11);
        tick();
        idle();
        set_rd2(4'd13);
        tick();
        settle();
        total++;
        if (do2_b !== 16'h0000 || v2_b !== 1'b1) begin
            bad++; $display("FAIL oor_read_b: got %h v=%0b expected 0000 v=1", do2_b, v2_b);
        end
        total++;
        if (do2_a !== 16'h5A5A) begin bad++; $display("FAIL oor_inrange_a: got %h expected 5a5a", do2_a); end
    endtask

    task automatic test_mid_reset();
        int na, nb;
        rst = 1;
        #1;
        total++;
        if (do1_a !== 16'h0 || busy_a !== 1'b1) begin
            bad++; $display("FAIL mid_rst_async: got d=%h busy=%0b expected 0000/1", do1_a, busy_a);
        end
        tick();
        rst = 0;
        repeat (8) tick();
        rst = 1;
        tick();
        rst = 0;
        set_wr1(4'd0, 16'hFFFF, 2'b11);
        set_rd2(4'd0);
        count_busy(na, nb, 1'b1);
        total++;
        if (na != 16) begin bad++; $display("FAIL mid_busy_len_a: got %0d expected 16", na); end
        total++;
        if (nb != 12) begin bad++; $display("FAIL mid_busy_len_b: got %0d expected 12", nb); end
        set_rd1(4'd0);
        set_rd2(4'd9);
        tick();
        settle();
        total++;
        if (do1_a !== 16'h0000 || v1_a !== 1'b1 || do1_b !== 16'h0000) begin
            bad++; $display("FAIL busy_write_lost: got %h/%h v=%0b expected 0000/0000 v=1",
                            do1_a, do1_b, v1_a);
        end
        total++;
        if (do2_a !== 16'h0000) begin bad++; $display("FAIL reclear: got %h expected 0000", do2_a); end
    endtask

    initial begin
        test_reset();
        test_read_init();
        test_byte_enable();
        test_rdw_mode();
        test_collision();
        test_out_of_range();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
